// File: rtl/axil_led_blinker_pkg.sv
// Shared definitions for the AXI4-Lite LED blinker: register map, CTRL bits,
// response codes, channel FSM states and the byte-lane merge helper.
package axil_led_blinker_pkg;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PERIOD  = 2'd1;
    localparam logic [1:0] ADDR_PATTERN = 2'd2;
    localparam logic [1:0] ADDR_SCRATCH = 2'd3;

    localparam int CTRL_EN_BIT        = 0;
    localparam int CTRL_STATIC_ON_BIT = 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_led_blinker_slave_if.sv
// AXI4-Lite bus bundle between a master and the LED blinker register slave.
interface axil_led_blinker_slave_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/led_blink_core.sv
// Blink engine: half-period counter, phase flip-flop and registered LED drive.
module led_blink_core #(
    parameter int LED_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 static_on_i,
    input  logic [31:0]          period_i,
    input  logic [LED_WIDTH-1:0] pattern_i,
    input  logic                 restart_i,
    output logic [LED_WIDTH-1:0] led_o
);
    logic [31:0]          count_q, count_d, last_s;
    logic                 phase_q, phase_d;
    logic [LED_WIDTH-1:0] led_q, led_d;

    // A zero period behaves as one, so the phase toggles every cycle.
    assign last_s = (period_i == 32'd0) ? 32'd0 : period_i - 32'd1;

    // Counter/phase next state and LED selection from the current phase.
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        led_d   = {LED_WIDTH{1'b0}};
        if (!en_i) begin
            count_d = 32'd0;
            phase_d = 1'b0;
        end else if (restart_i) begin
            count_d = 32'd0;
        end else if (count_q >= last_s) begin
            count_d = 32'd0;
            phase_d = ~phase_q;
        end else begin
            count_d = count_q + 32'd1;
        end
        if (en_i) begin
            led_d = phase_q ? pattern_i : {LED_WIDTH{1'b0}};
        end else begin
            led_d = static_on_i ? pattern_i : {LED_WIDTH{1'b0}};
        end
    end

    // Engine state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= 32'd0;
            phase_q <= 1'b0;
            led_q   <= {LED_WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
            led_q   <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/axil_led_blinker_slave.sv
// AXI4-Lite responder holding the CTRL/PERIOD/PATTERN/SCRATCH registers that
// drive the LED blink engine.
module axil_led_blinker_slave
    import axil_led_blinker_pkg::*;
#(
    parameter int          C_S00_AXI_DATA_WIDTH = 32,
    parameter int          C_S00_AXI_ADDR_WIDTH = 4,
    parameter int          LED_WIDTH            = 4,
    parameter logic [31:0] PERIOD_RESET         = 32'd50_000_000
) (
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_areset,
    axil_led_blinker_slave_if.slave s00_axi,
    output logic [LED_WIDTH-1:0]    led
);
    localparam int DW = C_S00_AXI_DATA_WIDTH;
    localparam int AW = C_S00_AXI_ADDR_WIDTH;

    logic [DW-1:0]   reg_q [4];
    wr_state_t       wr_state_q, wr_state_d;
    rd_state_t       rd_state_q, rd_state_d;
    logic            aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic            awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic            arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DW-1:0]   rdata_q, rdata_d, wdata_q;
    logic [DW/8-1:0] wstrb_q;
    logic [1:0]      awidx_q;
    logic            aw_hs_s, w_hs_s, aw_got_s, w_got_s, ar_hs_s, wr_commit_s, restart_s;
    logic [1:0]      wr_idx_s, rd_idx_s;
    logic [DW-1:0]   wr_data_s;
    logic [DW/8-1:0] wr_strb_s;
    logic            unused_s;

    assign unused_s = ^{s00_axi.awprot, s00_axi.arprot,
                        s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

    assign aw_hs_s  = s00_axi.awvalid & awready_q;
    assign w_hs_s   = s00_axi.wvalid & wready_q;
    assign ar_hs_s  = s00_axi.arvalid & arready_q;
    assign aw_got_s = aw_held_q | aw_hs_s;
    assign w_got_s  = w_held_q | w_hs_s;
    // Whichever half arrived earlier is taken from its capture register.
    assign wr_idx_s  = aw_held_q ? awidx_q : s00_axi.awaddr[AW-1:2];
    assign wr_data_s = w_held_q ? wdata_q : s00_axi.wdata;
    assign wr_strb_s = w_held_q ? wstrb_q : s00_axi.wstrb;
    assign rd_idx_s  = s00_axi.araddr[AW-1:2];
    assign restart_s = wr_commit_s & ((wr_idx_s == ADDR_CTRL) | (wr_idx_s == ADDR_PERIOD));

    // Write channel: collect AW and W independently, commit, then hold B.
    always_comb begin
        wr_state_d  = wr_state_q;
        aw_held_d   = aw_held_q;
        w_held_d    = w_held_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        wr_commit_s = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_got_s && w_got_s) begin
                    wr_commit_s = 1'b1;
                    wr_state_d  = W_RESP;
                    bvalid_d    = 1'b1;
                    aw_held_d   = 1'b0;
                    w_held_d    = 1'b0;
                    awready_d   = 1'b0;
                    wready_d    = 1'b0;
                end else begin
                    aw_held_d = aw_got_s;
                    w_held_d  = w_got_s;
                    awready_d = ~aw_got_s;
                    wready_d  = ~w_got_s;
                end
            end
            W_RESP: begin
                if (s00_axi.bready) begin
                    wr_state_d = W_IDLE;
                    bvalid_d   = 1'b0;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                end else begin
                    bvalid_d = 1'b1;
                end
            end
            default: begin
                wr_state_d = W_IDLE;
                bvalid_d   = 1'b0;
                aw_held_d  = 1'b0;
                w_held_d   = 1'b0;
            end
        endcase
    end

    // Read channel: sample the register on AR, hold R until accepted.
    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    rd_state_d = R_DATA;
                    arready_d  = 1'b0;
                    rvalid_d   = 1'b1;
                    rdata_d    = reg_q[rd_idx_s];
                end else begin
                    arready_d = 1'b1;
                    rvalid_d  = 1'b0;
                end
            end
            R_DATA: begin
                if (s00_axi.rready) begin
                    rd_state_d = R_IDLE;
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                end else begin
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                end
            end
            default: begin
                rd_state_d = R_IDLE;
                rvalid_d   = 1'b0;
                arready_d  = 1'b0;
            end
        endcase
    end

    // Channel state, handshake outputs and early-arrival capture registers.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= {DW{1'b0}};
            awidx_q    <= 2'd0;
            wdata_q    <= {DW{1'b0}};
            wstrb_q    <= {(DW/8){1'b0}};
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            if (aw_hs_s) begin
                awidx_q <= s00_axi.awaddr[AW-1:2];
            end
            if (w_hs_s) begin
                wdata_q <= s00_axi.wdata;
                wstrb_q <= s00_axi.wstrb;
            end
        end
    end

    // Register file; reads on the same edge see the pre-write contents.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            reg_q[ADDR_CTRL]    <= {DW{1'b0}};
            reg_q[ADDR_PERIOD]  <= PERIOD_RESET;
            reg_q[ADDR_PATTERN] <= {DW{1'b0}};
            reg_q[ADDR_SCRATCH] <= {DW{1'b0}};
        end else if (wr_commit_s) begin
            reg_q[wr_idx_s] <= merge_bytes(reg_q[wr_idx_s], wr_data_s, wr_strb_s);
        end
    end

    assign s00_axi.awready = awready_q;
    assign s00_axi.wready  = wready_q;
    assign s00_axi.bvalid  = bvalid_q;
    assign s00_axi.bresp   = RESP_OKAY;
    assign s00_axi.arready = arready_q;
    assign s00_axi.rvalid  = rvalid_q;
    assign s00_axi.rdata   = rdata_q;
    assign s00_axi.rresp   = RESP_OKAY;

    led_blink_core #(
        .LED_WIDTH(LED_WIDTH)
    ) u_core (
        .clk_i       (s00_axi_aclk),
        .rst_i       (s00_axi_areset),
        .en_i        (reg_q[ADDR_CTRL][CTRL_EN_BIT]),
        .static_on_i (reg_q[ADDR_CTRL][CTRL_STATIC_ON_BIT]),
        .period_i    (reg_q[ADDR_PERIOD]),
        .pattern_i   (reg_q[ADDR_PATTERN][LED_WIDTH-1:0]),
        .restart_i   (restart_s),
        .led_o       (led)
    );

endmodule

// File: tb/tb_axil_led_blinker_slave.sv
// Randomised scoreboard bench for the AXI4-Lite LED blinker slave.
module tb_axil_led_blinker_slave;

    localparam logic [31:0] PERIOD_RESET = 32'd50_000_000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  led;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] model [4];
    logic [1:0]  bq [$];
    logic [31:0] rq [$];
    logic [31:0] r_exp;
    logic [1:0]  b_exp;

    axil_led_blinker_slave_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

    axil_led_blinker_slave dut (
        .s00_axi_aclk   (clk),
        .s00_axi_areset (rst),
        .s00_axi        (bus),
        .led            (led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: pops an expectation whenever a B or R beat is accepted.
    always @(negedge clk) begin
        if (!rst && bus.bvalid && bus.bready) begin
            check("b_expected_pending", 32'(bq.size() > 0), 32'd1);
            if (bq.size() > 0) begin
                b_exp = bq.pop_front();
                check("bresp", 32'(bus.bresp), 32'(b_exp));
            end
        end
        if (!rst && bus.rvalid && bus.rready) begin
            check("r_expected_pending", 32'(rq.size() > 0), 32'd1);
            if (rq.size() > 0) begin
                r_exp = rq.pop_front();
                check("rdata", bus.rdata, r_exp);
                check("rresp", 32'(bus.rresp), 32'd0);
            end
        end
    end

    task automatic model_reset();
        model[0] = 32'd0;
        model[1] = PERIOD_RESET;
        model[2] = 32'd0;
        model[3] = 32'd0;
    endtask

    // Called and returns at posedge+1. commit_cyc is the cycle of the later AW/W handshake.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int hold, output int commit_cyc);
        int aw_c;
        int w_c;
        int b_c;
        aw_c = -1;
        w_c  = -1;
        b_c  = -1;
        fork
            begin
                repeat (aw_dly) @(posedge clk);
                #1;
                bus.awaddr  = addr;
                bus.awvalid = 1'b1;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (bus.awready) begin
                        aw_c = cyc;
                        break;
                    end
                end
                @(posedge clk);
                #1;
                bus.awvalid = 1'b0;
            end
            begin
                repeat (w_dly) @(posedge clk);
                #1;
                bus.wdata  = data;
                bus.wstrb  = strb;
                bus.wvalid = 1'b1;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (bus.wready) begin
                        w_c = cyc;
                        break;
                    end
                end
                @(posedge clk);
                #1;
                bus.wvalid = 1'b0;
            end
        join
        check("aw_accepted", 32'(aw_c >= 0), 32'd1);
        check("w_accepted", 32'(w_c >= 0), 32'd1);
        commit_cyc = (aw_c > w_c) ? aw_c : w_c;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) model[addr[3:2]][8*b +: 8] = data[8*b +: 8];
        end
        bq.push_back(2'b00);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.bvalid) begin
                b_c = cyc;
                break;
            end
        end
        check("b_latency", 32'(b_c), 32'(commit_cyc + 1));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bvalid_hold", 32'(bus.bvalid), 32'd1);
            check("awready_in_resp", 32'(bus.awready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.bready = 1'b1;
        @(posedge clk);
        #1;
        bus.bready = 1'b0;
    endtask

    // Called and returns at posedge+1; expectation is the model value at the AR handshake.
    task automatic axi_read(input logic [3:0] addr, input int hold);
        int ok;
        ok = 0;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.arready) begin
                rq.push_back(model[addr[3:2]]);
                ok = 1;
                break;
            end
        end
        check("ar_accepted", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        bus.arvalid = 1'b0;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.rvalid) begin
                ok = 1;
                break;
            end
        end
        check("rvalid_seen", 32'(ok), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("rvalid_hold", 32'(bus.rvalid), 32'd1);
            check("arready_while_rvalid", 32'(bus.arready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.rready = 1'b1;
        @(posedge clk);
        #1;
        bus.rready = 1'b0;
    endtask

    // LED after m edges past enabling: phase flips every max(P,1) cycles, LED lags one cycle.
    task automatic led_run(input logic [31:0] per, input logic [31:0] pat, input int ncyc);
        int k;
        int p;
        int m;
        logic [3:0] exp;
        axi_write(4'h0, 32'h0, 4'hF, 0, 0, 0, k);
        axi_write(4'h4, per, 4'hF, 0, 0, 0, k);
        axi_write(4'h8, pat, 4'hF, 0, 0, 0, k);
        axi_write(4'h0, 32'h1, 4'hF, 0, 0, 0, k);
        p = (per == 32'd0) ? 1 : int'(per);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            m = cyc - k - 1;
            exp = (m >= 1 && (((m - 1) / p) % 2) == 1) ? pat[3:0] : 4'h0;
            check("led_blink", 32'(led), 32'(exp));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;
        logic [31:0] d;
        bus.awaddr = 4'h0; bus.awprot = 3'd0; bus.awvalid = 1'b0;
        bus.wdata = 32'h0; bus.wstrb = 4'h0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = 4'h0; bus.arprot = 3'd0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_awready", 32'(bus.awready), 32'd0);
        check("rst_wready", 32'(bus.wready), 32'd0);
        check("rst_arready", 32'(bus.arready), 32'd0);
        check("rst_bvalid", 32'(bus.bvalid), 32'd0);
        check("rst_rvalid", 32'(bus.rvalid), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_led", 32'(led), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic write-then-readback.
        for (int i = 0; i < 4; i++) axi_write(4'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0, k);
        for (int i = 0; i < 4; i++) axi_read(4'(4 * i), 0);

        // AW/W skew with back-pressured B.
        axi_write(4'hC, 32'h1234_5678, 4'hF, 0, 3, 5, k);
        axi_write(4'hC, 32'h8765_4321, 4'hF, 3, 0, 5, k);
        axi_read(4'hC, 2);

        // Byte strobes.
        axi_write(4'h8, 32'h0, 4'hF, 0, 0, 0, k);
        axi_write(4'h8, 32'hAABB_CCDD, 4'b0101, 0, 0, 0, k);
        axi_read(4'h8, 0);

        // Randomised traffic, including odd addr[1:0] and partial strobes.
        for (int i = 0; i < 24; i++) begin
            axi_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 2)), k);
            if ($urandom_range(0, 1) == 1) axi_read(4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
        end
        for (int i = 0; i < 4; i++) axi_read(4'(4 * i + $urandom_range(0, 3)), 0);

        // Read and write of the same register on the same edge.
        d = $urandom;
        fork
            axi_write(4'hC, d, 4'hF, 0, 0, 0, k);
            axi_read(4'hC, 0);
        join
        axi_read(4'hC, 0);

        // Blink engine.
        led_run(32'd3, 32'hA, 16);
        led_run(32'd0, 32'($urandom_range(1, 15)), 8);
        led_run(32'($urandom_range(1, 4)), 32'($urandom_range(1, 15)), 14);

        // Static on / off.
        axi_write(4'h0, 32'h0, 4'hF, 0, 0, 0, k);
        axi_write(4'h8, 32'h5, 4'hF, 0, 0, 0, k);
        axi_write(4'h0, 32'h2, 4'hF, 0, 0, 0, k);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("led_static_on", 32'(led), 32'h5);
        end
        @(posedge clk);
        #1;
        axi_write(4'h0, 32'h0, 4'hF, 0, 0, 0, k);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("led_off", 32'(led), 32'h0);
        end
        @(posedge clk);
        #1;

        // Asynchronous reset while a read response is pending.
        axi_write(4'h4, 32'h0000_0077, 4'hF, 0, 0, 0, k);
        axi_write(4'h8, 32'hF, 4'hF, 0, 0, 0, k);
        axi_write(4'h0, 32'h2, 4'hF, 0, 0, 0, k);
        bus.araddr  = 4'h4;
        bus.arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.arready) break;
        end
        @(posedge clk);
        #1;
        bus.arvalid = 1'b0;
        @(negedge clk);
        check("rvalid_before_reset", 32'(bus.rvalid), 32'd1);
        check("led_before_reset", 32'(led), 32'hF);
        #2;
        rst = 1'b1;
        #1;
        check("rvalid_async_reset", 32'(bus.rvalid), 32'd0);
        check("arready_async_reset", 32'(bus.arready), 32'd0);
        check("led_async_reset", 32'(led), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) axi_read(4'(4 * i), 0);
        check("led_after_reset", 32'(led), 32'd0);

        repeat (3) @(negedge clk);
        check("bq_drained", 32'(bq.size()), 32'd0);
        check("rq_drained", 32'(rq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axil_led_blinker_slave.md
Name: axil_led_blinker_slave

Overview:
AXI4-Lite responder (slave) for the LED blinker peripheral. It terminates S00_AXI transactions from the master VIP or PS into four 32-bit registers. A blink engine driven by those registers produces the LED outputs. It is the register/response end of the write-then-readback flow used by the block-design bench.

Parameters:
C_S00_AXI_DATA_WIDTH, 32, data width (only 32 supported)
C_S00_AXI_ADDR_WIDTH, 4, byte address width; register index = addr[3:2]
LED_WIDTH, 4, number of LED outputs (1..32)
PERIOD_RESET, 32'd50_000_000, reset value of PERIOD register (clocks per half-period)

Ports:
s00_axi_aclk  in  1  single clock, all logic rising-edge
s00_axi_areset  in  1  asynchronous, active-high reset
s00_axi_awaddr  in  C_S00_AXI_ADDR_WIDTH  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid / s00_axi_awready  in/out  1  write address handshake
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  byte enables
s00_axi_wvalid / s00_axi_wready  in/out  1  write data handshake
s00_axi_bresp  out  2  always 2'b00 OKAY
s00_axi_bvalid / s00_axi_bready  out/in  1  write response handshake
s00_axi_araddr  in  C_S00_AXI_ADDR_WIDTH  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid / s00_axi_arready  in/out  1  read address handshake
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  always 2'b00 OKAY
s00_axi_rvalid / s00_axi_rready  out/in  1  read data handshake
led  out  LED_WIDTH  LED drive

Behaviour:
- Register map: 0x0 CTRL (bit0 EN, bit1 STATIC_ON, rest stored), 0x4 PERIOD, 0x8 PATTERN, 0xC SCRATCH. All RW with full 32-bit readback. addr[1:0] ignored.
- Reset values: CTRL=0, PERIOD=PERIOD_RESET, PATTERN=0, SCRATCH=0. All ready/valid outputs 0, rdata=0, bresp/rresp=0, led=0, counter=0, phase=0.
- Write channel FSM W_IDLE -> W_RESP -> W_IDLE:
  - In W_IDLE, awready=1 until AW is captured, and wready=1 until W is captured. AW and W are accepted independently, in either order or in the same cycle.
  - Once both are held, the register commits on that edge, byte-wise per wstrb. bvalid rises on the next cycle and the FSM enters W_RESP.
  - In W_RESP, awready=wready=0. bvalid holds until bready; the FSM returns to W_IDLE on the B handshake.
  - One write outstanding maximum. Minimum AW/W-to-B latency is 1 cycle.
- Read channel FSM R_IDLE -> R_DATA -> R_IDLE:
  - In R_IDLE, arready=1. On the AR handshake, rdata is loaded from the addressed register's value at that edge, and rvalid rises the next cycle.
  - rdata and rvalid are held stable until rready, then the FSM returns to R_IDLE. arready=0 while rvalid=1.
- Simultaneous write commit and read of the same register: the read returns the pre-write value.
- Read and write channels are fully independent; both may complete in the same cycle.
- Blink engine:
  - EN=1: 32-bit counter increments each cycle. At counter==max(PERIOD,1)-1 the counter wraps to 0 and phase toggles. PERIOD=0 behaves as 1, i.e. phase toggles every cycle.
  - EN=1 output: led = phase ? PATTERN[LED_WIDTH-1:0] : 0.
  - EN=0: counter=0 and phase=0. led = STATIC_ON ? PATTERN[LED_WIDTH-1:0] : 0.
  - Any write to PERIOD or CTRL (any strobe) clears the counter to 0 on the commit edge; phase is unchanged. If PERIOD is lowered below the current count, the clear prevents a missed wrap.
  - led is registered, so it lags the phase/register change by 1 cycle.
- Reset mid-transaction: all FSMs return to IDLE and pending B/R responses are dropped; the master sees valid=0 immediately, asynchronously.

Decomposition:
- Package axil_led_blinker_pkg holds:
  - register offsets ADDR_CTRL=2'd0, ADDR_PERIOD=2'd1, ADDR_PATTERN=2'd2, ADDR_SCRATCH=2'd3;
  - CTRL bit positions;
  - RESP_OKAY=2'b00;
  - enums wr_state_t {W_IDLE, W_RESP} and rd_state_t {R_IDLE, R_DATA}.
- One sub-module: led_blink_core (counter, phase, led register). Its inputs are en, static_on, period, pattern and restart.
- The AXI responder and register file stay in the top module.

Test Plan:
- Write 1,2,3,4 to 0x0,0x4,0x8,0xC via AXI4LITE_WRITE_BURST, then read back -> rdata 0x1,0x2,0x3,0x4, all bresp/rresp=OKAY.
- AW presented 3 cycles before W, and separately W 3 cycles before AW -> single commit, bvalid exactly 1 cycle after the later handshake. With bready held low 5 cycles, bvalid stays high and awready=0.
- Write 0x00 to 0x8 (PATTERN), then 0xAABBCCDD to 0x8 with wstrb=4'b0101 -> readback 0x00BB00DD.
- PERIOD=3, PATTERN=0xA, CTRL=0x1 -> led alternates 0x0/0xA every 3 cycles. PERIOD=0 -> led toggles every cycle.
- CTRL=0x2 with PATTERN=0x5 -> led=0x5 constant. CTRL=0x0 -> led=0x0.
- Assert reset while rvalid=1 and rready=0 -> rvalid=0, all registers at reset values. Read of 0x4 afterwards returns PERIOD_RESET.
